// File: rtl/pc_sequencer_if.sv
// pc_sequencer_if: bundles the PC-register, instruction-memory and decode
// signals around the fetch/issue sequencer.
//   master : the sequencer (drives pc_en/pc_next, imem_req/addr, inst*, epc,
//            retired, misalign, halted)
//   slave  : the surrounding PC register, instruction memory and decode stage
interface pc_sequencer_if;
  logic [31:0] pc_cur;
  logic        pc_en;
  logic [31:0] pc_next;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_ready;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        trap;
  logic        halt;
  logic [31:0] epc;
  logic [31:0] retired;
  logic        misalign;
  logic        halted;

  modport master (
    input  pc_cur, imem_ack, imem_rdata, inst_ready,
           redirect_valid, redirect_target, trap, halt,
    output pc_en, pc_next, imem_req, imem_addr, inst_valid, inst, inst_pc,
           epc, retired, misalign, halted
  );

  modport slave (
    output pc_cur, imem_ack, imem_rdata, inst_ready,
           redirect_valid, redirect_target, trap, halt,
    input  pc_en, pc_next, imem_req, imem_addr, inst_valid, inst, inst_pc,
           epc, retired, misalign, halted
  );
endinterface

// File: rtl/pc_sequencer.sv
// pc_sequencer: fetch/issue controller for the PC register.
// Ports:
//   clk    - clock, all state changes on the rising edge
//   reset  - synchronous active-low reset
//   bus    - pc_sequencer_if.master: PC register enable/data, instruction
//            memory handshake, decode handshake and next-PC decision inputs,
//            plus epc/retired/misalign/halted status
// Next-PC priority on consumption: trap > halt > redirect > sequential.
module pc_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] TRAP_VEC = 32'h0000_0080
) (
  input  logic           clk,
  input  logic           reset,
  pc_sequencer_if.master bus
);

  localparam int unsigned XLEN = 32;

  typedef enum logic [1:0] {
    ST_BOOT,
    ST_FETCH,
    ST_ISSUE,
    ST_HALTED
  } state_t;

  state_t            state_q, state_d;
  logic [XLEN-1:0]   inst_q, inst_d;
  logic [XLEN-1:0]   inst_pc_q, inst_pc_d;
  logic [XLEN-1:0]   epc_q, epc_d;
  logic [XLEN-1:0]   retired_q, retired_d;

  logic              pc_en_c;
  logic [XLEN-1:0]   pc_next_c;
  logic              misalign_c;

  // State and held-instruction registers
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= ST_BOOT;
      inst_q    <= '0;
      inst_pc_q <= '0;
      epc_q     <= '0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      inst_q    <= inst_d;
      inst_pc_q <= inst_pc_d;
      epc_q     <= epc_d;
      retired_q <= retired_d;
    end
  end

  // Next-state and next-PC decision
  always_comb begin
    state_d    = state_q;
    inst_d     = inst_q;
    inst_pc_d  = inst_pc_q;
    epc_d      = epc_q;
    retired_d  = retired_q;
    pc_en_c    = 1'b0;
    pc_next_c  = bus.pc_cur;   // hold value whenever the register is not loaded
    misalign_c = 1'b0;

    case (state_q)
      ST_BOOT: begin
        pc_en_c   = 1'b1;
        pc_next_c = RESET_PC;
        state_d   = ST_FETCH;
      end

      ST_FETCH: begin
        if (bus.imem_ack) begin
          inst_d    = bus.imem_rdata;
          inst_pc_d = bus.pc_cur;
          state_d   = ST_ISSUE;
        end
      end

      ST_ISSUE: begin
        if (bus.inst_ready) begin
          if (bus.trap) begin
            // Trapping instruction does not retire
            pc_en_c   = 1'b1;
            pc_next_c = TRAP_VEC;
            epc_d     = inst_pc_q;
            state_d   = ST_FETCH;
          end else if (bus.halt) begin
            retired_d = retired_q + XLEN'(1);
            state_d   = ST_HALTED;
          end else if (bus.redirect_valid) begin
            // Target is word-aligned by dropping the low bits; flag if any were set
            pc_en_c    = 1'b1;
            pc_next_c  = {bus.redirect_target[XLEN-1:2], 2'b00};
            misalign_c = |bus.redirect_target[1:0];
            retired_d  = retired_q + XLEN'(1);
            state_d    = ST_FETCH;
          end else begin
            pc_en_c   = 1'b1;
            pc_next_c = bus.pc_cur + XLEN'(4);
            retired_d = retired_q + XLEN'(1);
            state_d   = ST_FETCH;
          end
        end
      end

      ST_HALTED: begin
        state_d = ST_HALTED;
      end
    endcase
  end

  assign bus.pc_en      = pc_en_c;
  assign bus.pc_next    = pc_next_c;
  assign bus.misalign   = misalign_c;
  assign bus.imem_addr  = bus.pc_cur;
  assign bus.imem_req   = (state_q == ST_FETCH);
  assign bus.inst_valid = (state_q == ST_ISSUE);
  assign bus.halted     = (state_q == ST_HALTED);
  assign bus.inst       = inst_q;
  assign bus.inst_pc    = inst_pc_q;
  assign bus.epc        = epc_q;
  assign bus.retired    = retired_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed bench for pc_sequencer. An instruction-level
// model (fetch / issue / decision per transaction) predicts every output of
// every cycle; a single compare process checks them, and literal pins fix
// hand-computed values at key points.
module tb_pc_sequencer;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] TRAP_VEC = 32'h0000_0080;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  pc_sequencer_if bus ();

  pc_sequencer #(
    .RESET_PC (RESET_PC),
    .TRAP_VEC (TRAP_VEC)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // External PC register driven by the sequencer
  logic [31:0] pc_reg = 32'hDEAD_BEE0;
  always @(posedge clk) if (bus.pc_en === 1'b1) pc_reg <= bus.pc_next;
  assign bus.pc_cur = pc_reg;

  int n_checks = 0;
  int n_pass   = 0;

  // Model state (instruction level)
  logic [31:0] m_pc, m_inst, m_inst_pc, m_epc, m_retired;

  // Expected outputs for the current cycle
  logic        e_on = 1'b0;
  logic        e_req, e_valid, e_halted, e_pc_en, e_misalign;
  logic [31:0] e_pc_next, e_addr, e_inst, e_inst_pc, e_epc, e_retired;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s t=%0t actual=%h required=%h", name, $time, act, exp);
  endtask

  // Single compare process, sampling mid-cycle
  always @(negedge clk) begin
    #2;
    if (e_on) begin
      chk("imem_req",   32'(bus.imem_req),   32'(e_req));
      if (e_req) chk("imem_addr", bus.imem_addr, e_addr);
      chk("inst_valid", 32'(bus.inst_valid), 32'(e_valid));
      chk("halted",     32'(bus.halted),     32'(e_halted));
      chk("pc_en",      32'(bus.pc_en),      32'(e_pc_en));
      chk("pc_next",    bus.pc_next,         e_pc_next);
      chk("misalign",   32'(bus.misalign),   32'(e_misalign));
      chk("inst",       bus.inst,            e_inst);
      chk("inst_pc",    bus.inst_pc,         e_inst_pc);
      chk("epc",        bus.epc,             e_epc);
      chk("retired",    bus.retired,         e_retired);
    end
  end

  task automatic drive(input logic ack, input logic [31:0] rdata, input logic rdy,
                       input logic rv, input logic [31:0] tgt, input logic tr, input logic hl);
    bus.imem_ack        = ack;
    bus.imem_rdata      = rdata;
    bus.inst_ready      = rdy;
    bus.redirect_valid  = rv;
    bus.redirect_target = tgt;
    bus.trap            = tr;
    bus.halt            = hl;
  endtask

  task automatic expect_cycle(input logic req, input logic valid, input logic hlt,
                              input logic pen, input logic [31:0] pnext, input logic mis);
    e_req      = req;
    e_valid    = valid;
    e_halted   = hlt;
    e_pc_en    = pen;
    e_pc_next  = pnext;
    e_misalign = mis;
    e_addr     = m_pc;
    e_inst     = m_inst;
    e_inst_pc  = m_inst_pc;
    e_epc      = m_epc;
    e_retired  = m_retired;
    e_on       = 1'b1;
  endtask

  // One reset cycle then the BOOT cycle; ack may be held to show it is ignored
  task automatic do_reset(input logic ack_during);
    @(negedge clk);
    e_on  = 1'b0;
    reset = 1'b0;
    drive(ack_during, 32'hBAD2_0000, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    m_inst = '0; m_inst_pc = '0; m_epc = '0; m_retired = '0;
    @(negedge clk);
    reset = 1'b1;
    drive(ack_during, 32'hBAD2_0001, 1'b1, 1'b1, 32'h444, 1'b1, 1'b1);
    expect_cycle(1'b0, 1'b0, 1'b0, 1'b1, RESET_PC, 1'b0);
    m_pc = RESET_PC;
  endtask

  // Fetch with ack after ack_dly wait cycles; decode inputs toggled but ignored
  task automatic fetch(input int ack_dly, input logic [31:0] data);
    for (int i = 0; i <= ack_dly; i++) begin
      @(negedge clk);
      drive(i == ack_dly, (i == ack_dly) ? data : 32'hBAD0_0000 + 32'(i),
            1'b1, 1'b1, 32'h444, 1'b1, 1'b1);
      expect_cycle(1'b1, 1'b0, 1'b0, 1'b0, m_pc, 1'b0);
    end
    m_inst    = data;
    m_inst_pc = m_pc;
  endtask

  // Issue with ready after rdy_dly wait cycles; decision applied on consumption
  task automatic issue(input int rdy_dly, input logic rv, input logic [31:0] tgt,
                       input logic tr, input logic hl);
    logic [31:0] nx;
    for (int i = 0; i <= rdy_dly; i++) begin
      @(negedge clk);
      if (i != rdy_dly) begin
        drive(1'b1, 32'hBAD1_0000, 1'b0, 1'b1, 32'h444, 1'b1, 1'b1);
        expect_cycle(1'b0, 1'b1, 1'b0, 1'b0, m_pc, 1'b0);
      end else begin
        drive(1'b1, 32'hBAD1_0001, 1'b1, rv, tgt, tr, hl);
        if (tr) begin
          expect_cycle(1'b0, 1'b1, 1'b0, 1'b1, TRAP_VEC, 1'b0);
          m_epc = m_inst_pc;
          m_pc  = TRAP_VEC;
        end else if (hl) begin
          expect_cycle(1'b0, 1'b1, 1'b0, 1'b0, m_pc, 1'b0);
          m_retired = m_retired + 32'd1;
        end else if (rv) begin
          nx = tgt & ~32'h3;
          expect_cycle(1'b0, 1'b1, 1'b0, 1'b1, nx, (tgt % 4) != 0);
          m_retired = m_retired + 32'd1;
          m_pc      = nx;
        end else begin
          nx = m_pc + 32'd4;
          expect_cycle(1'b0, 1'b1, 1'b0, 1'b1, nx, 1'b0);
          m_retired = m_retired + 32'd1;
          m_pc      = nx;
        end
      end
    end
  endtask

  task automatic halted_idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      drive(1'b1, 32'hBAD3_0000, 1'b1, 1'b1, 32'h444, 1'b0, 1'b0);
      expect_cycle(1'b0, 1'b0, 1'b1, 1'b0, m_pc, 1'b0);
    end
  endtask

  // Move to just after the next rising edge for literal pins
  task automatic pin_wait();
    @(posedge clk);
    #1;
  endtask

  initial begin
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    m_pc = pc_reg; m_inst = '0; m_inst_pc = '0; m_epc = '0; m_retired = '0;

    // Back-to-back sequential stream from reset
    do_reset(1'b0);
    for (int k = 0; k < 4; k++) begin
      fetch(0, 32'h1000_0000 + 32'(k));
      issue(0, 1'b0, 32'h0, 1'b0, 1'b0);
    end
    pin_wait();
    chk("pin_retired_4", bus.retired, 32'd4);
    chk("pin_addr_10",   bus.imem_addr, 32'h10);

    // Delays, redirect, trap, halt
    do_reset(1'b0);
    fetch(0, 32'h2000_0000); issue(0, 1'b0, 32'h0, 1'b0, 1'b0);          // @0
    fetch(3, 32'h2000_0004); issue(2, 1'b0, 32'h0, 1'b0, 1'b0);          // @4 delayed
    fetch(0, 32'h2000_0008); issue(0, 1'b1, 32'h0000_0102, 1'b0, 1'b0);  // @8 redirect
    pin_wait();
    chk("pin_addr_100", bus.imem_addr, 32'h100);
    chk("pin_retired_3", bus.retired, 32'd3);
    fetch(1, 32'h2000_0100); issue(0, 1'b0, 32'h0, 1'b0, 1'b0);          // @100
    fetch(0, 32'h2000_0104); issue(1, 1'b1, 32'h0000_0010, 1'b0, 1'b0);  // @104 -> 10
    fetch(0, 32'h2000_0010); issue(0, 1'b1, 32'h0000_0300, 1'b1, 1'b1);  // @10 trap
    pin_wait();
    chk("pin_addr_80",   bus.imem_addr, 32'h80);
    chk("pin_epc_10",    bus.epc, 32'h10);
    chk("pin_retired_5", bus.retired, 32'd5);
    fetch(0, 32'h2000_0080); issue(0, 1'b1, 32'h0000_0020, 1'b0, 1'b0);  // @80 -> 20
    fetch(0, 32'h2000_0020); issue(0, 1'b0, 32'h0, 1'b0, 1'b1);          // @20 halt
    pin_wait();
    chk("pin_halted",    32'(bus.halted), 32'd1);
    chk("pin_retired_7", bus.retired, 32'd7);
    halted_idle(4);

    // Reset out of HALTED, then wrap from the top of memory
    do_reset(1'b0);
    pin_wait();
    chk("pin_addr_reset", bus.imem_addr, RESET_PC);
    fetch(0, 32'h3000_0000); issue(0, 1'b1, 32'hFFFF_FFFC, 1'b0, 1'b0);
    fetch(0, 32'h3FFF_FFFC); issue(0, 1'b0, 32'h0, 1'b0, 1'b0);
    pin_wait();
    chk("pin_addr_wrap", bus.imem_addr, 32'h0);

    // Reset mid-FETCH with a late ack that must be ignored
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      drive(1'b0, 32'hBAD4_0000, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
      expect_cycle(1'b1, 1'b0, 1'b0, 1'b0, m_pc, 1'b0);
    end
    do_reset(1'b1);
    fetch(1, 32'h4000_0000);
    pin_wait();
    chk("pin_inst_after_reset",    bus.inst, 32'h4000_0000);
    chk("pin_inst_pc_after_reset", bus.inst_pc, RESET_PC);
    issue(0, 1'b0, 32'h0, 1'b0, 1'b0);
    pin_wait();
    chk("pin_retired_1", bus.retired, 32'd1);

    @(negedge clk);
    e_on = 1'b0;
    #3;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
